cm82_serial_add_sched: RTL

Digit-serial addition scheduler that shares one external CM82 2-bit adder slice among several requesters. It arbitrates round-robin between requesters, streams each granted OP_W-bit addition through the slice two bits per cycle, and feeds the slice carry back as the next carry-in. The final sum and carry-out are returned on a single valid/ready response channel. It sits between the requester-side logic and the one mapped CM82 instance.

---
 rtl/cm82_serial_add_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cm82_serial_add_sched.sv
// Digit-serial addition scheduler: round-robin arbitration of several requesters onto one
// external CM82 2-bit adder slice, two bits per cycle, result on a valid/ready channel.
module cm82_serial_add_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned OP_W  = 8,
  localparam int unsigned IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [N_REQ*OP_W-1:0]   req_x_i,
  input  logic [N_REQ*OP_W-1:0]   req_y_i,
  input  logic [N_REQ-1:0]        req_cin_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IDW-1:0]          resp_id_o,
  output logic [OP_W-1:0]         resp_sum_o,
  output logic                    resp_cout_o,
  output logic                    busy_o,
  output logic                    slc_a_o,
  output logic                    slc_b_o,
  output logic                    slc_c_o,
  output logic                    slc_d_o,
  output logic                    slc_e_o,
  input  logic                    slc_f_i,
  input  logic                    slc_g_i,
  input  logic                    slc_h_i
);

  localparam int unsigned ND = OP_W / 2;
  localparam int unsigned KW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, id_q, id_d, gnt_idx, cand;
  logic [KW-1:0]   k_q, k_d;
  logic [OP_W-1:0] x_q, x_d, y_q, y_d, sum_q, sum_d;
  logic            cout_q, cout_d;
  logic [4:0]      slc_q, slc_d;
  logic            resp_valid_q, busy_q, gnt_found;
  logic [OP_W-1:0] x_arr [N_REQ];
  logic [OP_W-1:0] y_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign x_arr[g] = req_x_i[g*OP_W +: OP_W];
    assign y_arr[g] = req_y_i[g*OP_W +: OP_W];
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDW'((32'(rr_q) + i) % N_REQ);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Accept strobe is combinational; gated by reset so nothing is offered while held in reset.
  assign req_ready_o = (state_q == IDLE && gnt_found && rst_ni) ? (N_REQ'(1) << gnt_idx) : '0;

  // Slice inputs are registered one cycle ahead, so slc_a carries the previous slice carry.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    slc_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          state_d = RUN;
          id_d    = gnt_idx;
          k_d     = '0;
          sum_d   = '0;
          x_d     = x_arr[gnt_idx] >> 2;
          y_d     = y_arr[gnt_idx] >> 2;
          slc_d   = {req_cin_i[gnt_idx], x_arr[gnt_idx][0], y_arr[gnt_idx][0],
                     x_arr[gnt_idx][1], y_arr[gnt_idx][1]};
        end
      end
      RUN: begin
        sum_d = (sum_q >> 2) | (OP_W'({slc_g_i, slc_f_i}) << (OP_W - 2));
        k_d   = k_q + KW'(1);
        if (k_q == KW'(ND - 1)) begin
          cout_d  = slc_h_i;
          state_d = RESP;
        end else begin
          slc_d = {slc_h_i, x_q[0], y_q[0], x_q[1], y_q[1]};
          x_d   = x_q >> 2;
          y_d   = y_q >> 2;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rr_d    = (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      id_q         <= '0;
      k_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      slc_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      id_q         <= id_d;
      k_q          <= k_d;
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      slc_q        <= slc_d;
      resp_valid_q <= (state_d == RESP);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign busy_o       = busy_q;
  assign resp_id_o    = id_q;
  assign resp_sum_o   = sum_q;
  assign resp_cout_o  = cout_q;
  assign {slc_a_o, slc_b_o, slc_c_o, slc_d_o, slc_e_o} = slc_q;

endmodule
